// File: rtl/mux_n_1_pipe_pkg.sv
// Purpose: shared mode encodings and width helper for the N:1 pipelined selector.
// Latency: n/a (constants and a compile-time function only).
// Backpressure: n/a.
package mux_n_1_pipe_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Index width for n channels; never returns 0 so a 1-channel build still has a legal vector.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_1_pipe_if.sv
// Purpose: producer-side and consumer-side signals of the N:1 selector in one bundle.
// Latency: n/a (wiring only).
// Backpressure: in_ready per channel toward producers, out_ready from the single consumer.
interface mux_n_1_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 16
);
    import mux_n_1_pipe_pkg::*;

    localparam int SEL_W = clog2_min1(NUM_CH);

    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_ready;
    logic                    sel_err;

    // Environment side: drives the producers' channels and the consumer's ready.
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch, sel_err
    );

    // Selector side.
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch, sel_err
    );

endinterface

// File: rtl/mux_n_1_pipe_rr_arbiter.sv
// Purpose: round-robin grant over req, starting the search at ptr and wrapping modulo NUM_CH.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter
    import mux_n_1_pipe_pkg::*;
#(
    parameter  int NUM_CH = 16,
    localparam int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    // Two copies of req: masking off bits below ptr in the low copy leaves the
    // wrapped-around requests visible in the high copy, so one lowest-bit search
    // gives round-robin order without a modulo inside the search.
    logic [2*NUM_CH-1:0] req_dbl;
    logic [2*NUM_CH-1:0] mask;
    logic [2*NUM_CH-1:0] masked;

    assign req_dbl = {req, req};
    assign masked  = req_dbl & mask;

    // Keep every position at or above ptr.
    always_comb begin
        mask = '0;
        for (int i = 0; i < 2*NUM_CH; i++) begin
            mask[i] = (i >= int'(ptr));
        end
    end

    // Lowest surviving bit wins; scanning downward lets the last hit be the lowest.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 2*NUM_CH-1; i >= 0; i--) begin
            if (masked[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(i % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/mux_n_1_pipe.sv
// Purpose: N:1 selector (explicit sel or round-robin) feeding one registered output stage.
// Latency: 1 cycle from accepted input to out_valid/out_data.
// Backpressure: a slot opens when the register is empty or draining; otherwise all in_ready are 0.
module mux_n_1_pipe
    import mux_n_1_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_n_1_pipe_if.slave bus
);

    localparam int SEL_W = clog2_min1(NUM_CH);

    logic              slot_open;
    logic              sel_in_range;
    logic              arb_vld;
    logic [SEL_W-1:0]  arb_idx;
    logic              gnt_vld;
    logic [SEL_W-1:0]  gnt_idx;
    logic [WIDTH-1:0]  gnt_data;
    logic              gnt_req;
    logic [NUM_CH-1:0] gnt_onehot;
    logic              xfer;
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  rr_next;

    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic [SEL_W-1:0]  out_ch_q;
    logic              sel_err_q;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
        .req     (bus.in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Refill in the same cycle the consumer drains, so throughput stays at one word per cycle.
    assign slot_open = !out_valid_q || bus.out_ready;

    // Compared as int so non-power-of-two channel counts reject the unused sel codes.
    assign sel_in_range = int'(bus.sel) < NUM_CH;

    // Pick the grant source for the current mode; mode switches apply immediately.
    always_comb begin
        if (bus.mode == MODE_RR) begin
            gnt_idx = arb_idx;
            gnt_vld = arb_vld;
        end else begin
            gnt_idx = bus.sel;
            gnt_vld = sel_in_range;
        end
    end

    // Decode the grant with an explicit compare per channel so no sel value can index past the bus.
    always_comb begin
        gnt_data   = '0;
        gnt_req    = 1'b0;
        gnt_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_idx == SEL_W'(k)) begin
                gnt_data      = bus.in_data[k*WIDTH +: WIDTH];
                gnt_req       = bus.in_valid[k];
                gnt_onehot[k] = 1'b1;
            end
        end
    end

    // Ready is offered without looking at the granted channel's valid; reset masks it entirely.
    assign bus.in_ready = (rst_n && slot_open && gnt_vld) ? gnt_onehot : '0;
    assign xfer         = rst_n && slot_open && gnt_vld && gnt_req;

    assign rr_next = (gnt_idx == SEL_W'(NUM_CH-1)) ? '0 : gnt_idx + SEL_W'(1);

    // Output stage: load on transfer, empty when drained with nothing new, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= gnt_data;
            out_ch_q    <= gnt_idx;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Round-robin pointer moves past the winner only on a round-robin transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer && (bus.mode == MODE_RR)) begin
            rr_ptr <= rr_next;
        end
    end

    // Sticky flag for an out-of-range select seen while a slot was open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else if ((bus.mode == MODE_SEL) && slot_open && !sel_in_range) begin
            sel_err_q <= 1'b1;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Purpose: directed checks of the N:1 selector at 16 and 10 channels.
// Latency: expects 1 cycle input->output.
// Backpressure: exercises held output under out_ready=0 and no-bubble refill.
module tb_mux_n_1_pipe;

    logic clk;
    logic rst_n;

    mux_n_1_pipe_if #(.WIDTH(32), .NUM_CH(16)) bus16 ();
    mux_n_1_pipe_if #(.WIDTH(32), .NUM_CH(10)) bus10 ();

    mux_n_1_pipe #(.WIDTH(32), .NUM_CH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    mux_n_1_pipe #(.WIDTH(32), .NUM_CH(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [3:0]  sel;
        logic [15:0] vld;
        logic        ordy;
        logic [15:0] exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_od;
        logic [3:0]  exp_ch;
    } vec_t;

    vec_t       tbl [10];
    logic [3:0] exp_seq [3];
    int         n_chk;
    int         n_fail;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus16.mode = 1'b0; bus16.sel = '0; bus16.in_valid = '0; bus16.out_ready = 1'b1;
        bus10.mode = 1'b0; bus10.sel = '0; bus10.in_valid = '0; bus10.out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;

        // after reset rr_ptr=0; cycle-by-cycle state carried row to row
        tbl[0] = '{1'b0, 4'd5,  16'h0020, 1'b1, 16'h0020, 1'b1, 32'hDEADBEEF, 4'd5};
        tbl[1] = '{1'b0, 4'd3,  16'h0000, 1'b1, 16'h0008, 1'b0, 32'hDEADBEEF, 4'd5};
        tbl[2] = '{1'b0, 4'd3,  16'h0008, 1'b0, 16'h0008, 1'b1, 32'hC0DE0003, 4'd3};
        tbl[3] = '{1'b0, 4'd7,  16'hFFFF, 1'b0, 16'h0000, 1'b1, 32'hC0DE0003, 4'd3};
        tbl[4] = '{1'b1, 4'd0,  16'h0204, 1'b1, 16'h0004, 1'b1, 32'hC0DE0002, 4'd2};
        tbl[5] = '{1'b1, 4'd0,  16'h0204, 1'b1, 16'h0200, 1'b1, 32'hC0DE0009, 4'd9};
        tbl[6] = '{1'b1, 4'd0,  16'h0004, 1'b1, 16'h0004, 1'b1, 32'hC0DE0002, 4'd2};
        tbl[7] = '{1'b1, 4'd0,  16'h0000, 1'b1, 16'h0000, 1'b0, 32'hC0DE0002, 4'd2};
        tbl[8] = '{1'b0, 4'd15, 16'h8000, 1'b1, 16'h8000, 1'b1, 32'hC0DE000F, 4'd15};
        tbl[9] = '{1'b1, 4'd0,  16'h000A, 1'b1, 16'h0008, 1'b1, 32'hC0DE0003, 4'd3};
        exp_seq[0] = 4'd3;
        exp_seq[1] = 4'd14;
        exp_seq[2] = 4'd3;

        for (int k = 0; k < 16; k++)
            bus16.in_data[k*32 +: 32] = (k == 5) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(k));
        for (int k = 0; k < 10; k++)
            bus10.in_data[k*32 +: 32] = 32'hC0DE0000 | 32'(k);
        idle();

        // ---- reset with random inputs ----
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tick();
            bus16.mode = 1'($urandom); bus16.sel = 4'($urandom);
            bus16.in_valid = 16'($urandom); bus16.out_ready = 1'($urandom);
            bus10.mode = 1'($urandom); bus10.sel = 4'($urandom);
            bus10.in_valid = 10'($urandom); bus10.out_ready = 1'($urandom);
            #1;
            chk("rst_out_valid16", 64'(bus16.out_valid), 64'd0);
            chk("rst_out_data16",  64'(bus16.out_data),  64'd0);
            chk("rst_in_ready16",  64'(bus16.in_ready),  64'd0);
            chk("rst_sel_err16",   64'(bus16.sel_err),   64'd0);
            chk("rst_in_ready10",  64'(bus10.in_ready),  64'd0);
            chk("rst_sel_err10",   64'(bus10.sel_err),   64'd0);
        end
        idle();
        #2 rst_n = 1'b1;
        tick();
        tick();
        chk("idle_out_valid16", 64'(bus16.out_valid), 64'd0);
        chk("idle_out_valid10", 64'(bus10.out_valid), 64'd0);
        chk("idle_sel_err10",   64'(bus10.sel_err),   64'd0);

        // ---- table-driven vectors on the 16-channel instance ----
        for (int i = 0; i < 10; i++) begin
            bus16.mode      = tbl[i].mode;
            bus16.sel       = tbl[i].sel;
            bus16.in_valid  = tbl[i].vld;
            bus16.out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 64'(bus16.in_ready), 64'(tbl[i].exp_rdy));
            tick();
            chk($sformatf("vec%0d_out_valid", i), 64'(bus16.out_valid), 64'(tbl[i].exp_ov));
            chk($sformatf("vec%0d_out_data", i),  64'(bus16.out_data),  64'(tbl[i].exp_od));
            chk($sformatf("vec%0d_out_ch", i),    64'(bus16.out_ch),    64'(tbl[i].exp_ch));
        end

        // ---- back-pressure: capture, hold 3 cycles, refill with no bubble ----
        bus16.mode = 1'b0; bus16.sel = 4'd5; bus16.in_valid = 16'h0020; bus16.out_ready = 1'b1;
        tick();
        chk("bp_cap_data", 64'(bus16.out_data), 64'hDEADBEEF);
        chk("bp_cap_ch",   64'(bus16.out_ch),   64'd5);
        bus16.out_ready = 1'b0; bus16.sel = 4'd6; bus16.in_valid = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_hold%0d_in_ready", c), 64'(bus16.in_ready), 64'd0);
            tick();
            chk($sformatf("bp_hold%0d_valid", c), 64'(bus16.out_valid), 64'd1);
            chk($sformatf("bp_hold%0d_data", c),  64'(bus16.out_data),  64'hDEADBEEF);
            chk($sformatf("bp_hold%0d_ch", c),    64'(bus16.out_ch),    64'd5);
        end
        bus16.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(bus16.in_ready), 64'h0040);
        tick();
        chk("bp_refill_valid", 64'(bus16.out_valid), 64'd1);
        chk("bp_refill_data",  64'(bus16.out_data),  64'hC0DE0006);
        chk("bp_refill_ch",    64'(bus16.out_ch),    64'd6);

        // ---- mid-operation reset ----
        bus16.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus16.out_valid), 64'd0);
        chk("midrst_out_data",  64'(bus16.out_data),  64'd0);
        chk("midrst_in_ready",  64'(bus16.in_ready),  64'd0);
        tick();
        bus16.mode = 1'b1; bus16.in_valid = 16'hFFFF; bus16.out_ready = 1'b1;
        #1;
        chk("midrst_held_in_ready", 64'(bus16.in_ready), 64'd0);
        #1 rst_n = 1'b1;
        #1;
        chk("postrst_rr_first", 64'(bus16.in_ready), 64'h0001);

        // ---- round-robin over all 16 channels ----
        for (int i = 0; i < 17; i++) begin
            tick();
            chk($sformatf("rr_all%0d_ch", i),    64'(bus16.out_ch),    64'(i % 16));
            chk($sformatf("rr_all%0d_valid", i), 64'(bus16.out_valid), 64'd1);
        end
        bus16.in_valid = 16'h4000;
        #1;
        chk("rr_to14_in_ready", 64'(bus16.in_ready), 64'h4000);
        tick();
        chk("rr_to14_ch", 64'(bus16.out_ch), 64'd14);
        bus16.in_valid = 16'h4008;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk($sformatf("rr_3_14_step%0d", j), 64'(bus16.out_ch), 64'(exp_seq[j]));
        end
        idle();
        tick();

        // ---- out-of-range select on the 10-channel instance ----
        bus10.mode = 1'b0; bus10.sel = 4'd12; bus10.in_valid = 10'h3FF; bus10.out_ready = 1'b1;
        #1;
        chk("oor_in_ready", 64'(bus10.in_ready), 64'd0);
        tick();
        chk("oor_sel_err_set", 64'(bus10.sel_err),   64'd1);
        chk("oor_out_valid",   64'(bus10.out_valid), 64'd0);
        tick();
        chk("oor_sel_err_sticky", 64'(bus10.sel_err), 64'd1);
        bus10.sel = 4'd2; bus10.in_valid = 10'h004;
        #1;
        chk("oor_recover_in_ready", 64'(bus10.in_ready), 64'h004);
        tick();
        chk("oor_recover_valid",   64'(bus10.out_valid), 64'd1);
        chk("oor_recover_data",    64'(bus10.out_data),  64'hC0DE0002);
        chk("oor_recover_ch",      64'(bus10.out_ch),    64'd2);
        chk("oor_sel_err_still",   64'(bus10.sel_err),   64'd1);
        chk("sel_err16_clear",     64'(bus16.sel_err),   64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
